// File: rtl/psum_drain.sv
// Partial-sum drain: pops aligned rows from a column FIFO bank and serializes
// them one word per handshake, column 0 first, flagging the final word of a tile.
module psum_drain #(
  parameter int OUT_DATA_WIDTH = 32,
  parameter int COL            = 8,
  parameter int LOG_COL        = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic [7:0]                    num_rows,
  input  logic                          isempty,
  output logic                          read_en,
  input  logic [OUT_DATA_WIDTH*COL-1:0] fifo_data,
  output logic [OUT_DATA_WIDTH-1:0]     out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [1:0] {IDLE, POP, LOAD, SEND} state_t;

  state_t                               state_q, state_d;
  logic [7:0]                           rows_q;
  logic [LOG_COL-1:0]                   col_q;
  logic [COL-1:0][OUT_DATA_WIDTH-1:0]   row_q;
  logic                                 done_q;
  logic                                 accept;
  logic                                 col_end;
  logic                                 last_row;

  assign accept   = (state_q == SEND) && out_ready;
  assign col_end  = (col_q == LOG_COL'(COL - 1));
  assign last_row = (rows_q == 8'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rows_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= accept && col_end && last_row;
      case (state_q)
        IDLE: if (start) rows_q <= (num_rows == 8'd0) ? 8'd1 : num_rows;
        LOAD: begin
          row_q <= fifo_data;
          col_q <= '0;
        end
        SEND: if (accept) begin
          // index parks at COL-1 on the row's last word; LOAD rezeroes it
          if (col_end) rows_q <= rows_q - 8'd1;
          else         col_q  <= col_q + LOG_COL'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    read_en   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = POP;
      POP: if (!isempty) begin
        read_en = 1'b1;
        state_d = LOAD;
      end
      LOAD: state_d = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (accept && col_end) state_d = last_row ? IDLE : POP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight off the row register, so a stall holds them for free
  assign out_data = out_valid ? row_q[col_q] : '0;
  assign out_last = out_valid && col_end && last_row;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_psum_drain.sv
// Randomized bench for psum_drain: FIFO bank model plus a word scoreboard that
// derives order, out_last, done and busy from tile row counts.
module tb_psum_drain;
  localparam int W   = 32;
  localparam int COL = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [7:0]       num_rows;
  logic             isempty;
  logic             read_en;
  logic [W*COL-1:0] fifo_data;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             done;

  psum_drain #(.OUT_DATA_WIDTH(W), .COL(COL), .LOG_COL(3)) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_rows(num_rows),
    .isempty(isempty), .read_en(read_en), .fifo_data(fifo_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [W*COL-1:0] fifo_q[$];
  logic [W-1:0]     exp_q[$];
  logic             force_empty = 1'b0;
  int               mode = 0;
  logic             tile_active = 1'b0;
  int               tile_rows = 0;
  int               acc_cnt = 0;
  int               pops = 0;
  logic             exp_done = 1'b0;
  logic             hold_v = 1'b0;
  logic [W-1:0]     hold_d;
  logic             hold_l;
  int               cyc = 0;
  int               start_cyc = 0;
  int               done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    isempty = (fifo_q.size() == 0) || force_empty;
  endtask

  task automatic push_row(input logic [W*COL-1:0] r);
    fifo_q.push_back(r);
    upd_empty();
  endtask

  function automatic logic [W*COL-1:0] rand_row();
    logic [W*COL-1:0] r;
    for (int c = 0; c < COL; c++) r[c*W +: W] = $urandom;
    return r;
  endfunction

  // One clock: check at negedge, advance the models just after posedge
  task automatic step();
    logic acc, rd, st;
    logic [W*COL-1:0] r;
    @(negedge clk);
    chk("rd_while_empty", {31'b0, read_en & isempty}, 32'd0);
    chk("busy", {31'b0, busy}, {31'b0, tile_active});
    chk("done", {31'b0, done}, {31'b0, exp_done});
    if (!tile_active) chk("valid_outside_tile", {31'b0, out_valid}, 32'd0);
    if (out_valid && hold_v) begin
      chk("stall_data", out_data, hold_d);
      chk("stall_last", {31'b0, out_last}, {31'b0, hold_l});
    end
    acc = out_valid && out_ready;
    if (acc) begin
      if (exp_q.size() == 0) chk("extra_word", {31'b0, out_valid}, 32'd0);
      else begin
        acc_cnt++;
        chk("data", out_data, exp_q.pop_front());
        chk("last", {31'b0, out_last}, {31'b0, acc_cnt == tile_rows * COL});
      end
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    hold_l = out_last;
    rd = read_en;
    st = start && !tile_active;
    @(posedge clk); #1;
    cyc++;
    exp_done = 1'b0;
    if (acc && tile_active && acc_cnt == tile_rows * COL) begin
      chk("pops_per_tile", pops, tile_rows);
      tile_active = 1'b0;
      exp_done = 1'b1;
      done_cyc = cyc;
    end
    if (rd) begin
      pops++;
      if (fifo_q.size() != 0) begin
        r = fifo_q.pop_front();
        fifo_data = r;
        for (int c = 0; c < COL; c++) exp_q.push_back(r[c*W +: W]);
      end
    end
    if (st) begin
      tile_active = 1'b1;
      tile_rows = (num_rows == 8'd0) ? 1 : int'(num_rows);
      acc_cnt = 0;
      pops = 0;
      exp_q.delete();
      start_cyc = cyc - 1;
    end
    start = 1'b0;
    upd_empty();
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic begin_tile(input logic [7:0] n);
    num_rows = n;
    start = 1'b1;
    step();
  endtask

  task automatic run_tile();
    int k = 0;
    while (tile_active && k < 2000) begin
      step();
      k++;
    end
    chk("tile_timeout", {31'b0, tile_active}, 32'd0);
    step();  // done cycle
  endtask

  initial begin
    logic [W*COL-1:0] r;
    int p0, k;
    rstn = 1'b0; start = 1'b0; num_rows = 8'd0; out_ready = 1'b1;
    fifo_data = '0; upd_empty();
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_last", {31'b0, out_last}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_read_en", {31'b0, read_en}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step();

    // Two preloaded rows 0x00..0x07 / 0x10..0x17, ready tied high
    for (int rr = 0; rr < 2; rr++) begin
      for (int c = 0; c < COL; c++) r[c*W +: W] = W'(rr * 16 + c);
      push_row(r);
    end
    mode = 0;
    begin_tile(8'd2);
    run_tile();
    chk("throughput", done_cyc - start_cyc, 2 * (COL + 2) + 1);

    // FIFO held empty for 10 cycles after start
    push_row(rand_row());
    force_empty = 1'b1; upd_empty();
    begin_tile(8'd1);
    repeat (10) step();
    chk("no_pop_while_empty", pops, 0);
    force_empty = 1'b0; upd_empty();
    p0 = pops;
    step();
    chk("pop_after_empty", pops - p0, 1);
    run_tile();

    // Alternating backpressure
    mode = 1;
    push_row(rand_row()); push_row(rand_row());
    begin_tile(8'd2);
    run_tile();

    // num_rows = 0 behaves as one row
    mode = 0;
    push_row(rand_row());
    begin_tile(8'd0);
    run_tile();

    // start while busy must not disturb the running tile
    mode = 2;
    for (int i = 0; i < 3; i++) push_row(rand_row());
    begin_tile(8'd3);
    repeat (5) step();
    num_rows = 8'd1; start = 1'b1;
    step();
    chk("start_ignored_rows", tile_rows, 3);
    run_tile();

    // Reset in the middle of a row, then a fresh one-row tile
    mode = 0;
    push_row(rand_row()); push_row(rand_row());
    begin_tile(8'd2);
    k = 0;
    while (acc_cnt < 3 && k < 100) begin step(); k++; end
    chk("reach_col3", acc_cnt, 3);
    rstn = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    tile_active = 1'b0; exp_q.delete(); exp_done = 1'b0; hold_v = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    repeat (4) step();
    begin_tile(8'd1);
    run_tile();

    // Randomized tiles with random backpressure and empty gaps
    mode = 2;
    for (int t = 0; t < 6; t++) begin
      k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++) push_row(rand_row());
      force_empty = 1'($urandom_range(0, 1)); upd_empty();
      begin_tile(8'(k));
      repeat ($urandom_range(0, 4)) step();
      force_empty = 1'b0; upd_empty();
      run_tile();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
